vscale_hasti_arbiter: RTL and testbench

Two-master to one-slave HASTI (AHB-Lite subset) arbiter that lets the vscale core's instruction and data ports share a single `vscale_hasti_sram`. It sits between `vscale_hasti_wrapper` and the SRAM, and sequences address and data phases so each master sees a protocol-correct, stall-only view of the shared slave. A one-entry hold register per port absorbs an address phase that loses arbitration, so neither master is ever dropped.

---
 rtl/vscale_hasti_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_vscale_hasti_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_hasti_arbiter.sv
// ============================================================================
// vscale_hasti_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Lets two HASTI (AHB-Lite subset) masters share one slave. Port 0 is the
//   vscale instruction port, port 1 is the data port, and the slave is a
//   single vscale_hasti_sram. Address and data phases are sequenced so that
//   each master sees a protocol-correct view of the slave in which the only
//   side effect of sharing is extra stall cycles.
//
//   Each port has a one-entry hold register. An address phase that is
//   presented but cannot be issued this cycle is captured there, and the
//   master is stalled until the held transfer is issued and its data phase
//   completes. No request is ever dropped.
//
// Handshake semantics (single statement for every port):
//   A master's address phase is accepted in a cycle where its htrans[1]==1
//   and its hready==1. Once accepted it either goes straight to the slave
//   as a NONSEQ or is parked in that port's hold register. A master's data
//   phase completes in the cycle its hready==1 while it owns the slave data
//   phase. The slave accepts an address phase and completes a data phase
//   only in cycles where s_hready==1.
//
// Configuration:
//   VSCALE_HASTI_ARB_RR_EN
//     undefined : fixed priority, port 1 (dmem) beats port 0 (imem).
//     defined   : round-robin; a 'last granted' register (reset to 1) moves
//                 on every grant and the other port wins on contention.
//
// Ports:
//   hclk, hresetn            clock, asynchronous active-low reset
//   mN_haddr/hwrite/hsize/
//   hburst/hmastlock/hprot/
//   htrans                   master N address phase
//   mN_hwdata                master N write data (data phase)
//   mN_hrdata                read data, broadcast from the slave
//   mN_hready                per-master ready
//   mN_hresp                 per-master response (only the data-phase owner)
//   s_haddr ... s_htrans     address phase to the slave
//   s_hwdata                 write data of the data-phase owner
//   s_hrdata/hready/hresp    slave response
// ============================================================================
module vscale_hasti_arbiter (
  input  logic        hclk,
  input  logic        hresetn,

  // port 0 : imem
  input  logic [31:0] m0_haddr,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [2:0]  m0_hburst,
  input  logic        m0_hmastlock,
  input  logic [3:0]  m0_hprot,
  input  logic [1:0]  m0_htrans,
  input  logic [31:0] m0_hwdata,
  output logic [31:0] m0_hrdata,
  output logic        m0_hready,
  output logic        m0_hresp,

  // port 1 : dmem
  input  logic [31:0] m1_haddr,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [2:0]  m1_hburst,
  input  logic        m1_hmastlock,
  input  logic [3:0]  m1_hprot,
  input  logic [1:0]  m1_htrans,
  input  logic [31:0] m1_hwdata,
  output logic [31:0] m1_hrdata,
  output logic        m1_hready,
  output logic        m1_hresp,

  // shared slave
  output logic [31:0] s_haddr,
  output logic        s_hwrite,
  output logic [2:0]  s_hsize,
  output logic [2:0]  s_hburst,
  output logic        s_hmastlock,
  output logic [3:0]  s_hprot,
  output logic [1:0]  s_htrans,
  output logic [31:0] s_hwdata,
  input  logic [31:0] s_hrdata,
  input  logic        s_hready,
  input  logic        s_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Address-phase fields that have to be carried to the slave. htrans and
  // hburst are not stored: every issued transfer becomes a NONSEQ SINGLE.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic        mastlock;
    logic [3:0]  prot;
  } aphase_t;

  localparam aphase_t APHASE_ZERO = '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  aphase_t r_hold0;
  aphase_t r_hold1;
  logic    r_hold_v0;
  logic    r_hold_v1;
  logic    r_dval;       // a data phase is in progress on the slave
  logic    r_down;       // port that owns that data phase
  logic    r_sel_port;   // address mux select used in the last cycle
  logic    r_sel_hold;   // last mux select pointed at the hold register
`ifdef VSCALE_HASTI_ARB_RR_EN
  logic    r_last;       // port granted most recently
`endif

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  aphase_t w_live0;
  aphase_t w_live1;
  aphase_t w_ap;
  logic    w_m0_hready;
  logic    w_m1_hready;
  logic    w_req0;       // live request on port 0
  logic    w_req1;       // live request on port 1
  logic    w_pend0;
  logic    w_pend1;
  logic    w_prio1;      // port 1 wins if both ports are pending
  logic    w_gnt0;
  logic    w_gnt1;
  logic    w_gnt_any;
  logic    w_sel_port;
  logic    w_sel_hold;
  logic    w_unused;

  // htrans[0] (SEQ vs NONSEQ) and hburst are intentionally ignored.
  assign w_unused = ^{m0_htrans[0], m1_htrans[0], m0_hburst, m1_hburst};

  assign w_live0 = '{addr: m0_haddr, write: m0_hwrite, size: m0_hsize,
                     mastlock: m0_hmastlock, prot: m0_hprot};
  assign w_live1 = '{addr: m1_haddr, write: m1_hwrite, size: m1_hsize,
                     mastlock: m1_hmastlock, prot: m1_hprot};

  // Ready only depends on registers and s_hready, so the live-request terms
  // below do not form a combinational loop through the masters.
  // The data-phase owner follows the slave; any other port is stalled while
  // it has a parked request.
  assign w_m0_hready = (r_dval && (r_down == 1'b0)) ? s_hready : ~r_hold_v0;
  assign w_m1_hready = (r_dval && (r_down == 1'b1)) ? s_hready : ~r_hold_v1;

  assign w_req0  = m0_htrans[1] & w_m0_hready;
  assign w_req1  = m1_htrans[1] & w_m1_hready;
  assign w_pend0 = r_hold_v0 | w_req0;
  assign w_pend1 = r_hold_v1 | w_req1;

`ifdef VSCALE_HASTI_ARB_RR_EN
  // The port that was not granted last time goes first.
  assign w_prio1 = (r_last == 1'b0);
`else
  assign w_prio1 = 1'b1;
`endif

  // Arbitration only happens when the slave can take an address phase.
  // Reset also blocks grants so nothing reaches the slave while it is held.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (hresetn && s_hready) begin
      if (w_pend1 && (!w_pend0 || w_prio1)) begin
        w_gnt1 = 1'b1;
      end else if (w_pend0) begin
        w_gnt0 = 1'b1;
      end
    end
  end

  assign w_gnt_any = w_gnt0 | w_gnt1;

  // Without a grant the select from the previous cycle is reused, so the
  // address bus does not wander while the slave is stalled or idle.
  always_comb begin
    w_sel_port = r_sel_port;
    w_sel_hold = r_sel_hold;
    if (w_gnt1) begin
      w_sel_port = 1'b1;
      w_sel_hold = r_hold_v1;
    end else if (w_gnt0) begin
      w_sel_port = 1'b0;
      w_sel_hold = r_hold_v0;
    end
  end

  always_comb begin
    w_ap = w_live0;
    case ({w_sel_port, w_sel_hold})
      2'b00:   w_ap = w_live0;
      2'b01:   w_ap = r_hold0;
      2'b10:   w_ap = w_live1;
      default: w_ap = r_hold1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Slave-side outputs
  // --------------------------------------------------------------------------
  always_comb begin
    s_haddr     = '0;
    s_hwrite    = 1'b0;
    s_hsize     = '0;
    s_hburst    = HBURST_SINGLE;
    s_hmastlock = 1'b0;
    s_hprot     = '0;
    s_htrans    = HTRANS_IDLE;
    s_hwdata    = '0;
    // While reset is asserted the slave sees an all-zero IDLE bus.
    if (hresetn) begin
      s_haddr     = w_ap.addr;
      s_hwrite    = w_ap.write;
      s_hsize     = w_ap.size;
      s_hmastlock = w_ap.mastlock;
      s_hprot     = w_ap.prot;
      s_htrans    = w_gnt_any ? HTRANS_NONSEQ : HTRANS_IDLE;
      s_hwdata    = r_down ? m1_hwdata : m0_hwdata;
    end
  end

  // --------------------------------------------------------------------------
  // Master-side outputs
  // --------------------------------------------------------------------------
  assign m0_hready = w_m0_hready;
  assign m1_hready = w_m1_hready;
  assign m0_hresp  = r_dval & (r_down == 1'b0) & s_hresp;
  assign m1_hresp  = r_dval & (r_down == 1'b1) & s_hresp;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

  // --------------------------------------------------------------------------
  // Data-phase tracking and address select
  // --------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_dval     <= 1'b0;
      r_down     <= 1'b0;
      r_sel_port <= 1'b0;
      r_sel_hold <= 1'b0;
    end else begin
      if (w_gnt_any) begin
        r_dval <= 1'b1;
        r_down <= w_gnt1;
      end else if (s_hready) begin
        r_dval <= 1'b0;
      end
      r_sel_port <= w_sel_port;
      r_sel_hold <= w_sel_hold;
    end
  end

  // --------------------------------------------------------------------------
  // Hold registers. A port can never have a parked entry and an accepted
  // live request together, because the parked entry drives its hready low
  // (or it is the owner and the slave is stalled). The entry contents are
  // left in place after issue so a reused select still sees a stable value.
  // --------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_hold_v0 <= 1'b0;
      r_hold0   <= APHASE_ZERO;
    end else if (w_gnt0 && r_hold_v0) begin
      r_hold_v0 <= 1'b0;
    end else if (w_req0 && !w_gnt0) begin
      r_hold_v0 <= 1'b1;
      r_hold0   <= w_live0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_hold_v1 <= 1'b0;
      r_hold1   <= APHASE_ZERO;
    end else if (w_gnt1 && r_hold_v1) begin
      r_hold_v1 <= 1'b0;
    end else if (w_req1 && !w_gnt1) begin
      r_hold_v1 <= 1'b1;
      r_hold1   <= w_live1;
    end
  end

`ifdef VSCALE_HASTI_ARB_RR_EN
  // Reset value 1 lets imem win the first contention after reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_last <= 1'b1;
    end else if (w_gnt_any) begin
      r_last <= w_gnt1;
    end
  end
`endif

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// ============================================================================
// tb_vscale_hasti_arbiter
// Directed, table-driven bench. Each record holds one clock cycle of master
// and slave stimulus plus the arbiter outputs expected in that cycle. The
// slave side is driven straight from the table, so every expected value is
// a hand-derived constant. A short hand-written sequence after the mid-run
// reset exercises the priority scheme of the selected build.
// ============================================================================
module tb_vscale_hasti_arbiter;

  localparam logic [1:0]  ID = 2'b00;
  localparam logic [1:0]  NS = 2'b10;
  localparam logic [1:0]  SQ = 2'b11;
  localparam logic [31:0] A0 = 32'hA0A0_A0A0;  // constant m0 write data

  typedef struct {
    // stimulus
    logic        rstn;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic        w1;
    logic [31:0] wd1;
    logic        srdy;
    logic        sresp;
    logic [31:0] srd;
    // expectations
    logic        chk;     // compare address-phase fields this cycle
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_write;
    logic [3:0]  e_prot;
    logic [31:0] e_wdata;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_resp0;
    logic        e_resp1;
    logic [31:0] e_rdata;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  // ---------------- DUT signals ----------------
  logic [31:0] m0_haddr, m1_haddr;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic        m0_hmastlock, m1_hmastlock;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite, s_hmastlock, s_hready, s_hresp;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;

  vscale_hasti_arbiter dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hburst(m0_hburst), .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot),
    .m0_htrans(m0_htrans), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
    .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hburst(m1_hburst), .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot),
    .m1_htrans(m1_htrans), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
    .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hmastlock(s_hmastlock), .s_hprot(s_hprot),
    .s_htrans(s_htrans), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
    .s_hready(s_hready), .s_hresp(s_hresp)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rstn, input logic [1:0] t0, input logic [31:0] a0,
    input logic [1:0] t1, input logic [31:0] a1, input logic w1,
    input logic [31:0] wd1, input logic srdy, input logic sresp,
    input logic [31:0] srd,
    input logic chk, input logic [1:0] e_trans, input logic [31:0] e_addr,
    input logic e_write, input logic [3:0] e_prot, input logic [31:0] e_wdata,
    input logic e_rdy0, input logic e_rdy1, input logic e_resp0,
    input logic e_resp1);
    vec_t v;
    v.rstn = rstn; v.t0 = t0; v.a0 = a0; v.t1 = t1; v.a1 = a1; v.w1 = w1;
    v.wd1 = wd1; v.srdy = srdy; v.sresp = sresp; v.srd = srd;
    v.chk = chk; v.e_trans = e_trans; v.e_addr = e_addr; v.e_write = e_write;
    v.e_prot = e_prot; v.e_wdata = e_wdata; v.e_rdy0 = e_rdy0;
    v.e_rdy1 = e_rdy1; v.e_resp0 = e_resp0; v.e_resp1 = e_resp1;
    v.e_rdata = srd;  // read data is a plain broadcast
    return v;
  endfunction

  // ---------------- driver: one cycle per record ----------------
  // Entered just after a rising edge; drives, samples at the falling edge,
  // then advances past the next rising edge.
  task automatic run_vec(input vec_t v, input int idx);
    hresetn   = v.rstn;
    m0_htrans = v.t0;
    m0_haddr  = v.a0;
    m1_htrans = v.t1;
    m1_haddr  = v.a1;
    m1_hwrite = v.w1;
    m1_hwdata = v.wd1;
    s_hready  = v.srdy;
    s_hresp   = v.sresp;
    s_hrdata  = v.srd;
    @(negedge hclk);
    check("s_htrans",  idx, {30'd0, s_htrans},  {30'd0, v.e_trans});
    check("s_hburst",  idx, {29'd0, s_hburst},  32'd0);
    check("s_hwdata",  idx, s_hwdata,           v.e_wdata);
    check("m0_hready", idx, {31'd0, m0_hready}, {31'd0, v.e_rdy0});
    check("m1_hready", idx, {31'd0, m1_hready}, {31'd0, v.e_rdy1});
    check("m0_hresp",  idx, {31'd0, m0_hresp},  {31'd0, v.e_resp0});
    check("m1_hresp",  idx, {31'd0, m1_hresp},  {31'd0, v.e_resp1});
    check("m0_hrdata", idx, m0_hrdata,          v.e_rdata);
    check("m1_hrdata", idx, m1_hrdata,          v.e_rdata);
    if (v.chk) begin
      check("s_haddr",  idx, s_haddr,            v.e_addr);
      check("s_hwrite", idx, {31'd0, s_hwrite},  {31'd0, v.e_write});
      check("s_hprot",  idx, {28'd0, s_hprot},   {28'd0, v.e_prot});
    end
    @(posedge hclk);
    #1;
  endtask

  vec_t tbl[21];
  vec_t seq[6];

  initial begin
    // static master attributes; bursts are driven so their removal shows
    m0_hwrite = 1'b0; m0_hsize = 3'd2; m0_hburst = 3'b011;
    m0_hmastlock = 1'b0; m0_hprot = 4'h1; m0_hwdata = A0;
    m1_hsize = 3'd2; m1_hburst = 3'b101; m1_hmastlock = 1'b0; m1_hprot = 4'h3;
    m0_htrans = NS; m0_haddr = 32'h0000_0123;
    m1_htrans = NS; m1_haddr = 32'h0000_0456; m1_hwrite = 1'b1;
    m1_hwdata = 32'h0;
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h0;

    //            rstn t0  a0      t1  a1      w1 wd1           srdy sresp srd
    //            chk trans addr   wr prot wdata         rdy0 rdy1 rsp0 rsp1
    // imem alone: back-to-back, SEQ converted to NONSEQ
    tbl[0]  = mk(1, NS, 32'h0,   ID, 32'h0,   0, 32'h0,        1, 0, 32'h0,
                 1, NS, 32'h0,   0, 4'h1, A0,            1, 1, 0, 0);
    tbl[1]  = mk(1, SQ, 32'h4,   ID, 32'h0,   0, 32'h0,        1, 0, 32'h11,
                 1, NS, 32'h4,   0, 4'h1, A0,            1, 1, 0, 0);
    tbl[2]  = mk(1, SQ, 32'h8,   ID, 32'h0,   0, 32'h0,        1, 0, 32'h22,
                 1, NS, 32'h8,   0, 4'h1, A0,            1, 1, 0, 0);
    tbl[3]  = mk(1, ID, 32'h8,   ID, 32'h0,   0, 32'h0,        1, 0, 32'h33,
                 0, ID, 32'h0,   0, 4'h0, A0,            1, 1, 0, 0);
    // simultaneous NONSEQ: dmem write first, imem from hold next cycle
    tbl[4]  = mk(1, NS, 32'h100, NS, 32'h200, 1, 32'h0,        1, 0, 32'h0,
                 1, NS, 32'h200, 1, 4'h3, A0,            1, 1, 0, 0);
    tbl[5]  = mk(1, NS, 32'h100, ID, 32'h200, 0, 32'hDEADBEEF, 1, 0, 32'h0,
                 1, NS, 32'h100, 0, 4'h1, 32'hDEADBEEF,  0, 1, 0, 0);
    tbl[6]  = mk(1, ID, 32'h100, ID, 32'h0,   0, 32'h0,        1, 0, 32'h5555AAAA,
                 0, ID, 32'h0,   0, 4'h0, A0,            1, 1, 0, 0);
    tbl[7]  = mk(1, ID, 32'h0,   NS, 32'h200, 0, 32'h0,        1, 0, 32'h0,
                 1, NS, 32'h200, 0, 4'h3, A0,            1, 1, 0, 0);
    tbl[8]  = mk(1, ID, 32'h0,   ID, 32'h200, 0, 32'h0,        1, 0, 32'hDEADBEEF,
                 0, ID, 32'h0,   0, 4'h0, 32'h0,         1, 1, 0, 0);
    // two slave wait states on a dmem read, imem parked meanwhile
    tbl[9]  = mk(1, ID, 32'h0,   NS, 32'h300, 0, 32'h0,        1, 0, 32'h0,
                 1, NS, 32'h300, 0, 4'h3, 32'h0,         1, 1, 0, 0);
    tbl[10] = mk(1, NS, 32'h40,  ID, 32'h300, 0, 32'h0,        0, 0, 32'h0,
                 1, ID, 32'h300, 0, 4'h3, 32'h0,         1, 0, 0, 0);
    tbl[11] = mk(1, NS, 32'h40,  ID, 32'h300, 0, 32'h0,        0, 0, 32'h0,
                 1, ID, 32'h300, 0, 4'h3, 32'h0,         0, 0, 0, 0);
    tbl[12] = mk(1, NS, 32'h40,  ID, 32'h300, 0, 32'h0,        1, 0, 32'h77,
                 1, NS, 32'h40,  0, 4'h1, 32'h0,         0, 1, 0, 0);
    tbl[13] = mk(1, ID, 32'h0,   ID, 32'h0,   0, 32'h0,        1, 0, 32'h88,
                 0, ID, 32'h0,   0, 4'h0, A0,            1, 1, 0, 0);
    // two-cycle ERROR to dmem, imem captured during it and issued after
    tbl[14] = mk(1, ID, 32'h0,   NS, 32'h400, 1, 32'h0,        1, 0, 32'h0,
                 1, NS, 32'h400, 1, 4'h3, A0,            1, 1, 0, 0);
    tbl[15] = mk(1, NS, 32'h44,  ID, 32'h400, 1, 32'h12345678, 0, 1, 32'h0,
                 1, ID, 32'h400, 1, 4'h3, 32'h12345678,  1, 0, 0, 1);
    tbl[16] = mk(1, NS, 32'h44,  ID, 32'h400, 1, 32'h12345678, 1, 1, 32'h0,
                 1, NS, 32'h44,  0, 4'h1, 32'h12345678,  0, 1, 0, 1);
    tbl[17] = mk(1, ID, 32'h0,   ID, 32'h0,   0, 32'h0,        1, 0, 32'h0,
                 0, ID, 32'h0,   0, 4'h0, A0,            1, 1, 0, 0);
    // contention leaves imem parked, then reset hits mid-operation
    tbl[18] = mk(1, NS, 32'h600, NS, 32'h500, 0, 32'h0,        1, 0, 32'h0,
                 1, NS, 32'h500, 0, 4'h3, A0,            1, 1, 0, 0);
    tbl[19] = mk(0, NS, 32'h600, ID, 32'h0,   0, 32'h0,        1, 0, 32'h99,
                 1, ID, 32'h0,   0, 4'h0, 32'h0,         1, 1, 0, 0);
    tbl[20] = mk(1, ID, 32'h600, ID, 32'h0,   0, 32'h0,        1, 0, 32'h0,
                 0, ID, 32'h0,   0, 4'h0, A0,            1, 1, 0, 0);

    // Post-reset contention sequence; only the first two cycles depend on
    // the priority scheme (fixed: dmem first; round-robin: imem first).
`ifdef VSCALE_HASTI_ARB_RR_EN
    seq[0] = mk(1, NS, 32'h700, NS, 32'h800, 0, 32'h0, 1, 0, 32'h0,
                1, NS, 32'h700, 0, 4'h1, A0,     1, 1, 0, 0);
    seq[1] = mk(1, ID, 32'h0,   ID, 32'h0,   0, 32'h0, 1, 0, 32'h0,
                1, NS, 32'h800, 0, 4'h3, A0,     1, 0, 0, 0);
    seq[2] = mk(1, NS, 32'hB00, ID, 32'h0,   0, 32'h0, 1, 0, 32'h0,
                1, NS, 32'hB00, 0, 4'h1, 32'h0,  1, 1, 0, 0);
`else
    seq[0] = mk(1, NS, 32'h700, NS, 32'h800, 0, 32'h0, 1, 0, 32'h0,
                1, NS, 32'h800, 0, 4'h3, A0,     1, 1, 0, 0);
    seq[1] = mk(1, ID, 32'h0,   ID, 32'h0,   0, 32'h0, 1, 0, 32'h0,
                1, NS, 32'h700, 0, 4'h1, 32'h0,  0, 1, 0, 0);
    seq[2] = mk(1, NS, 32'hB00, ID, 32'h0,   0, 32'h0, 1, 0, 32'h0,
                1, NS, 32'hB00, 0, 4'h1, A0,     1, 1, 0, 0);
`endif
    // last grant was imem, so dmem wins the next contention in both builds
    seq[3] = mk(1, NS, 32'h900, NS, 32'hA00, 0, 32'h0, 1, 0, 32'h0,
                1, NS, 32'hA00, 0, 4'h3, A0,     1, 1, 0, 0);
    seq[4] = mk(1, ID, 32'h0,   ID, 32'h0,   0, 32'h0, 1, 0, 32'h0,
                1, NS, 32'h900, 0, 4'h1, 32'h0,  0, 1, 0, 0);
    seq[5] = mk(1, ID, 32'h0,   ID, 32'h0,   0, 32'h0, 1, 0, 32'h0,
                0, ID, 32'h0,   0, 4'h0, A0,     1, 1, 0, 0);

    // reset state, with both masters requesting during reset
    @(negedge hclk);
    check("rst_s_htrans",  -1, {30'd0, s_htrans},  {30'd0, ID});
    check("rst_s_haddr",   -1, s_haddr,            32'h0);
    check("rst_s_hwrite",  -1, {31'd0, s_hwrite},  32'd0);
    check("rst_s_hwdata",  -1, s_hwdata,           32'h0);
    check("rst_m0_hready", -1, {31'd0, m0_hready}, 32'd1);
    check("rst_m1_hready", -1, {31'd0, m1_hready}, 32'd1);
    check("rst_m0_hresp",  -1, {31'd0, m0_hresp},  32'd0);
    check("rst_m1_hresp",  -1, {31'd0, m1_hresp},  32'd0);
    @(posedge hclk);
    #1;

    for (int i = 0; i < 21; i++) run_vec(tbl[i], i);
    for (int i = 0; i < 6; i++)  run_vec(seq[i], 100 + i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
